// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the ram_arbiter block.
//   AW_DEF / DW_DEF : default memory address / data widths
//   state_e         : sequencer states (fill pass, arbitration)
//   port_id_t       : requester port identifier (port 0 or 1)
//   rd_tag_t        : read tag carried alongside an in-flight read
package ram_arb_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_ARB  = 1'b1
    } state_e;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_tag_t;
endpackage

// File: rtl/ram_arb_if.sv
// ram_arb_if: request/grant bundle between the ram_arbiter datapath and its
// round-robin grant logic.
//   valid0/valid1 : qualified request from port 0 / 1
//   xfer          : a grant was taken this cycle (valid and ready both high)
//   grant0/grant1 : one-hot grant back to the requesters
// master = side presenting requests, slave = side producing grants.
interface ram_arb_if;
    logic valid0;
    logic valid1;
    logic xfer;
    logic grant0;
    logic grant1;

    modport master (output valid0, output valid1, output xfer,
                    input  grant0, input  grant1);
    modport slave  (input  valid0, input  valid1, input  xfer,
                    output grant0, output grant1);
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant logic.
//   clock, resetn : clock and synchronous active-low reset
//   bus (slave)   : valid0/1 and xfer in, grant0/1 out
// last_q remembers the most recently granted port; on a tie the other port
// wins. It resets to 1 so port 0 takes the first tie.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic      clock,
    input  logic      resetn,
    ram_arb_if.slave  bus
);
    port_id_t last_q, last_d;

    assign bus.grant0 = bus.valid0 && (!bus.valid1 || (last_q == 1'b1));
    assign bus.grant1 = bus.valid1 && (!bus.valid0 || (last_q == 1'b0));

    always_comb begin
        last_d = last_q;
        if (bus.xfer) begin
            last_d = bus.grant1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter/sequencer for a single-port memory with
// registered address and unregistered q (one-cycle read latency).
//   clock, resetn            : clock, synchronous active-low reset
//   req_*0 / req_*1          : per-port request (valid/ready/we/addr/wdata)
//   rsp_valid*/rsp_data*     : per-port read response (one-cycle pulse)
//   busy                     : fill pass running, no requests accepted
//   mem_addr/mem_data/mem_wren : registered memory command
//   mem_q                    : memory read data
// Optional feature macro RAM_ARB_FILL_EN: after reset, write data=address to
// every location before arbitration starts.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          req_valid0,
    input  logic          req_valid1,
    output logic          req_ready0,
    output logic          req_ready1,
    input  logic          req_we0,
    input  logic          req_we1,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    output logic          rsp_valid0,
    output logic          rsp_valid1,
    output logic [DW-1:0] rsp_data0,
    output logic [DW-1:0] rsp_data1,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);
    logic arb_en;
    logic fill_active;

`ifdef RAM_ARB_FILL_EN
    state_e        state_q, state_d;
    logic [AW-1:0] fill_cnt_q, fill_cnt_d;

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        if (state_q == ST_FILL) begin
            fill_cnt_d = fill_cnt_q + AW'(1);
            if (fill_cnt_q == {AW{1'b1}}) begin
                state_d = ST_ARB;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    assign fill_active = (state_q == ST_FILL);
    assign busy        = fill_active;
    // resetn gates ready so nothing is granted while reset is held.
    assign arb_en      = resetn && (state_q == ST_ARB);
`else
    assign fill_active = 1'b0;
    assign busy        = 1'b0;
    assign arb_en      = resetn;
`endif

    ram_arb_if arb ();

    assign arb.valid0 = req_valid0 && arb_en;
    assign arb.valid1 = req_valid1 && arb_en;
    assign arb.xfer   = arb.grant0 || arb.grant1;
    assign req_ready0 = arb.grant0;
    assign req_ready1 = arb.grant1;

    rr_arb2 u_rr_arb2 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (arb.slave)
    );

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          mem_wren_q, mem_wren_d;
    rd_tag_t       tag1_q, tag1_d, tag2_q, tag2_d;
    logic          rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
    logic [DW-1:0] rsp_data0_q, rsp_data0_d, rsp_data1_q, rsp_data1_d;
    port_id_t      sel_port;
    logic          sel_we;

    assign sel_port = arb.grant1;
    assign sel_we   = sel_port ? req_we1 : req_we0;

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
        tag1_d     = '0;
`ifdef RAM_ARB_FILL_EN
        if (fill_active) begin
            mem_addr_d = fill_cnt_q;
            mem_data_d = DW'(fill_cnt_q);
            mem_wren_d = 1'b1;
        end else
`endif
        if (arb.xfer) begin
            mem_addr_d = sel_port ? req_addr1 : req_addr0;
            if (sel_we) begin
                mem_data_d = sel_port ? req_wdata1 : req_wdata0;
                mem_wren_d = 1'b1;
            end else begin
                tag1_d = '{valid: 1'b1, port: sel_port};
            end
        end
        // Stage 1 covers the memory's address register; stage 2 lines up
        // with q being valid, so capture happens at the stage-2 edge.
        tag2_d       = tag1_q;
        rsp_valid0_d = tag2_q.valid && (tag2_q.port == 1'b0);
        rsp_valid1_d = tag2_q.valid && (tag2_q.port == 1'b1);
        rsp_data0_d  = rsp_valid0_d ? mem_q : rsp_data0_q;
        rsp_data1_d  = rsp_valid1_d ? mem_q : rsp_data1_q;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wren_q   <= 1'b0;
            tag1_q       <= '0;
            tag2_q       <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_data0_q  <= '0;
            rsp_data1_q  <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wren_q   <= mem_wren_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_data0_q  <= rsp_data0_d;
            rsp_data1_q  <= rsp_data1_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_wren   = mem_wren_q;
    assign rsp_valid0 = rsp_valid0_q;
    assign rsp_valid1 = rsp_valid1_q;
    assign rsp_data0  = rsp_data0_q;
    assign rsp_data1  = rsp_data1_q;
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the single-port on-chip `memory` macro (address, clock, data, wren, q). Grants one access per cycle with round-robin fairness, drives the memory command lines from registers, and returns read data to the issuing port. It can optionally run a power-on fill pass that writes data equal to address into every location, as the RAM bring-up harness does.

## Interface
Parameters:
- AW, 8, memory address width; depth is 2^AW words
- DW, 8, memory data width

Ports:
- clock  in  1  single clock; all logic on rising edge
- resetn  in  1  synchronous reset, active low
- req_valid0 / req_valid1  in  1  request present on port 0 / 1
- req_ready0 / req_ready1  out  1  request accepted this cycle
- req_we0 / req_we1  in  1  1 = write, 0 = read
- req_addr0 / req_addr1  in  AW  word address
- req_wdata0 / req_wdata1  in  DW  write data
- rsp_valid0 / rsp_valid1  out  1  read data valid, one-cycle pulse
- rsp_data0 / rsp_data1  out  DW  read data
- busy  out  1  fill pass in progress; requests not accepted
- mem_addr  out  AW  to memory address
- mem_data  out  DW  to memory data
- mem_wren  out  1  to memory write enable
- mem_q  in  DW  from memory q

## Operation
- States: FILL (only with macro), ARB. Reset enters FILL if compiled in, else ARB.
- FILL: a fill counter runs 0..2^AW-1, one write per cycle, mem_addr=k, mem_data=k[DW-1:0] zero-extended or truncated, mem_wren=1. After k=2^AW-1 is issued, go to ARB. busy=1 throughout FILL, and req_ready0/1=0.
- ARB: req_readyX is combinational from req_valid and the round-robin pointer. Only one port is ready per cycle. A transfer happens when valid and ready are both high.
- Round robin: `last` holds the last granted port. When only one port is valid, that port is granted. When both are valid, the port other than `last` is granted. `last` updates only on a transfer. The reset value of `last` is 1, so port 0 wins the first tie.
- Accepted write: registered onto mem_addr/mem_data with mem_wren=1. No response.
- Accepted read: registered onto mem_addr with mem_wren=0. A tag recording port ID plus valid travels through a 2-stage pipeline. At stage 2, mem_q is captured into rsp_dataX and rsp_validX pulses for the tagged port only. The other port's rsp_data holds its value.
- When no transfer occurs, mem_wren=0 and mem_addr/mem_data hold their values.
- Accesses complete in acceptance order, so read-after-write to the same address returns the new data, across ports too.
- Reset mid-operation: in-flight read tags are discarded, no rsp_valid is issued, and the fill pass restarts from 0.

## Timing
- Reset values: req_ready0/1=0, rsp_valid0/1=0, rsp_data0/1=0, mem_addr=0, mem_data=0, mem_wren=0. busy=1 with the macro, 0 without.
- The memory has a registered address and unregistered q, giving a one-cycle read latency.
- Read latency, counting from accept edge N: the command is registered at N, the memory samples it at N+1, and rsp_data is captured at N+2. rsp_valid is high during the cycle after N+2.
- Throughput is one access per cycle with back-to-back grants allowed. Reads and writes are interleaved with no bubbles.
- Fill duration is 2^AW cycles after reset release (256 with defaults). The first ready can assert on cycle 2^AW.
- Without the macro, ready can assert in the first cycle after reset release.

## Configuration
- RAM_ARB_FILL_EN defined: the FILL state, fill counter and busy logic are compiled in. Memory contents after reset are data=address.
- RAM_ARB_FILL_EN undefined: there is no FILL state, busy is tied to 0, and memory contents are left untouched by reset.

## Structure
- Package ram_arb_pkg holds:
  - AW/DW defaults
  - the state enum (FILL, ARB)
  - the port-ID type (1 bit)
  - the read-tag struct {valid, port}
- Sub-module rr_arb2 is the 2-way round-robin grant logic: inputs valid0/1 and the transfer strobe, outputs grant0/1, and it holds the `last` register.
- The `memory` macro is instantiated by the parent, not inside ram_arbiter.

## Test plan
- Macro on, reset released: busy=1 for 256 cycles with mem writes addr=data 0x00..0xFF. Then busy=0. A port-0 read of 0x2A gives rsp_valid0 with rsp_data0=0x2A three cycles after accept.
- Both ports issue continuous reads of 0x01/0x02: grants alternate 0,1,0,1, starting with port 0. rsp_data0=0x01 and rsp_data1=0x02, with no cross-port pulses.
- Port 0 writes 0x10←0xA5 and port 1 reads 0x10 in the next cycle: rsp_data1=0xA5.
- Only port 1 valid for 4 cycles with addresses 0x05..0x08: 4 consecutive accepts, then 4 consecutive rsp_valid1 pulses, no stalls.
- resetn driven low the cycle after a read accept: no rsp_valid, all outputs at reset values, and the fill restarts at address 0.
- Macro off: a port-0 write is accepted on the first cycle after reset release, and busy is never 1.
